rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, register file address width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, register file data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports w0_valid/w1_valid  input  1 each  write request from requester 0 and requester 1.
REQ-006 SHALL have ports w0_addr/w1_addr  input  ADDR_WIDTH each  write address.
REQ-007 SHALL have ports w0_data/w1_data  input  DATA_WIDTH each  write data.
REQ-008 SHALL have ports w0_ready/w1_ready  output  1 each  combinational grant; the write is accepted when valid&&ready.
REQ-009 SHALL have port rd_valid  input  1  read request.
REQ-010 SHALL have port rd_addr  input  ADDR_WIDTH  read address.
REQ-011 SHALL have port rd_ready  output  1  read accepted when rd_valid&&rd_ready.
REQ-012 SHALL have port rd_resp_valid  output  1  read response strobe.
REQ-013 SHALL have port rd_resp_data  output  DATA_WIDTH  read response data.
REQ-014 SHALL have ports rf_wen  output  1, rf_waddr  output  ADDR_WIDTH, rf_wdata  output  DATA_WIDTH  registered drive of the register file write port.
REQ-015 SHALL have port rf_raddr  output  ADDR_WIDTH  combinational register file read address (equals rd_addr).
REQ-016 SHALL have port rf_rdata  input  DATA_WIDTH  combinational register file read data.
REQ-017 SHALL have port init_done  output  1  high once the clear sweep has completed.

Function
REQ-018 SHALL implement FSM states INIT and RUN; INIT -> RUN after the last clear write; RUN is terminal until reset.
REQ-019 In INIT, the block SHALL issue one clear write per cycle at addresses 0, 1, ... 2**ADDR_WIDTH-1 with data 0, using an ADDR_WIDTH+1-bit counter so the top address does not wrap to 0.
REQ-020 In INIT, w0_ready, w1_ready and rd_ready SHALL be 0.
REQ-021 init_done SHALL rise in the cycle after the registered clear write to address 2**ADDR_WIDTH-1 is presented on rf_wen; it SHALL remain high until reset.
REQ-022 In RUN, at most one write SHALL be granted per cycle.
REQ-023 If exactly one requester is valid, it SHALL be granted.
REQ-024 If both requesters are valid, the grant SHALL go to the requester that is not the last granted one; the round-robin pointer SHALL reset to favour requester 0.
REQ-025 The last-granted pointer SHALL update only on an accepted write.
REQ-026 ready SHALL NOT depend on the other requester's data or address, only on both valid signals, the pointer and the FSM state.
REQ-027 An accepted write SHALL appear on rf_wen/rf_waddr/rf_wdata exactly one cycle after acceptance (latency 1).
REQ-028 rf_wen SHALL be 0 in any cycle following a cycle with no accepted or clear write.
REQ-029 rd_ready SHALL equal init_done; reads SHALL never be blocked by writes.
REQ-030 An accepted read SHALL capture rf_rdata at the acceptance edge and present it with rd_resp_valid=1 in the next cycle (latency 1); rd_resp_valid SHALL be 1 for exactly one cycle per accepted read.
REQ-031 If a read and the registered rf_wen target the same address in the same cycle, the response SHALL carry the pre-write value (read-before-write).
REQ-032 Back-to-back reads SHALL be accepted every cycle.

Reset
REQ-033 On assertion of rst_n=0, the block SHALL asynchronously force: FSM=INIT, clear counter=0, rf_wen=0, rf_waddr=0, rf_wdata=0, rd_resp_valid=0, rd_resp_data=0, init_done=0, pointer=favour 0.
REQ-034 Reset asserted mid-sweep or mid-operation SHALL discard any in-flight write or read response, and the sweep SHALL restart from address 0 after release.

Verification
REQ-035 Scenario: ADDR_WIDTH=2; release reset -> rf_wen=1 with rf_waddr 0,1,2,3 and rf_wdata=0 on four consecutive cycles; init_done=1 on the next cycle; ready=0 throughout.
REQ-036 Scenario: both valid continuously, w0 addr 1 data 0xA, w1 addr 2 data 0xB -> grants alternate w0, w1, w0, ...; rf_waddr alternates 1, 2 one cycle later.
REQ-037 Scenario: only w1 valid for 3 cycles -> three grants to w1; then both valid -> w0 granted first.
REQ-038 Scenario: write addr 3 data 0x5C accepted, then a read of addr 3 in the rf_wen cycle -> response is old value 0; a read one cycle later returns 0x5C.
REQ-039 Scenario: rst_n pulsed low during the sweep at address 2 -> rf_wen=0 immediately; after release the sweep restarts at address 0.
REQ-040 Scenario: four back-to-back reads at addresses 0..3 after preloads 0x11..0x44 -> rd_resp_valid high four consecutive cycles with data 0x11, 0x22, 0x33, 0x44.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: clears the file after reset, then arbitrates two
// writers round-robin onto one registered write port and serves single-cycle reads.
module rf_write_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w0_valid,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,
  output logic                  w0_ready,
  input  logic                  w1_valid,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [DATA_WIDTH-1:0] w1_data,
  output logic                  w1_ready,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_resp_valid,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  init_done
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    last_q;          // 1: requester 1 was granted last
  logic                    rf_wen_q;
  logic [ADDR_WIDTH-1:0]   rf_waddr_q;
  logic [DATA_WIDTH-1:0]   rf_wdata_q;
  logic                    rd_resp_valid_q;
  logic [DATA_WIDTH-1:0]   rd_resp_data_q;
  logic                    init_done_q;

  logic w0_acc;
  logic w1_acc;
  logic rd_acc;
  logic sweep_last;

  // Grants depend only on the two valids, the pointer and the run state.
  assign w0_ready   = init_done_q & w0_valid & (~w1_valid | last_q);
  assign w1_ready   = init_done_q & w1_valid & (~w0_valid | ~last_q);
  assign w0_acc     = w0_valid & w0_ready;
  assign w1_acc     = w1_valid & w1_ready;
  assign rd_ready   = init_done_q;
  assign rd_acc     = rd_valid & init_done_q;
  assign sweep_last = (cnt_q == CNT_W'(DEPTH - 1));

  assign rf_raddr      = rd_addr;
  assign rf_wen        = rf_wen_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign rd_resp_valid = rd_resp_valid_q;
  assign rd_resp_data  = rd_resp_data_q;
  assign init_done     = init_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_INIT;
      cnt_q           <= '0;
      last_q          <= 1'b1;
      rf_wen_q        <= 1'b0;
      rf_waddr_q      <= '0;
      rf_wdata_q      <= '0;
      rd_resp_valid_q <= 1'b0;
      rd_resp_data_q  <= '0;
      init_done_q     <= 1'b0;
    end else begin
      rf_wen_q        <= 1'b0;
      rd_resp_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_resp_data_q <= rf_rdata;
      end
      case (state_q)
        ST_INIT: begin
          // One clear write per cycle; the extra counter bit keeps the top address from wrapping.
          rf_wen_q   <= 1'b1;
          rf_waddr_q <= cnt_q[ADDR_WIDTH-1:0];
          rf_wdata_q <= '0;
          cnt_q      <= cnt_q + CNT_W'(1);
          if (sweep_last) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
          if (w0_acc) begin
            rf_wen_q   <= 1'b1;
            rf_waddr_q <= w0_addr;
            rf_wdata_q <= w0_data;
            last_q     <= 1'b0;
          end else if (w1_acc) begin
            rf_wen_q   <= 1'b1;
            rf_waddr_q <= w1_addr;
            rf_wdata_q <= w1_data;
            last_q     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter with a behavioural register file and
// a transaction-level reference model for the randomized run.
module tb_rf_write_arbiter;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic          w0_valid, w1_valid, rd_valid;
  logic [AW-1:0] w0_addr, w1_addr, rd_addr;
  logic [DW-1:0] w0_data, w1_data;
  logic          w0_ready, w1_ready, rd_ready;
  logic          rd_resp_valid;
  logic [DW-1:0] rd_resp_data;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr, rf_raddr;
  logic [DW-1:0] rf_wdata, rf_rdata;
  logic          init_done;

  int checks   = 0;
  int failures = 0;

  rf_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .w0_valid(w0_valid), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ready(w0_ready),
    .w1_valid(w1_valid), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ready(w1_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .init_done(init_done)
  );

  // Behavioural register file: combinational read, write on the clock edge.
  logic [DW-1:0] rf_mem [4];
  always @(posedge clk) if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    w0_valid = 0; w1_valid = 0; rd_valid = 0;
    w0_addr = '0; w1_addr = '0; rd_addr = '0;
    w0_data = '0; w1_data = '0;
  endtask

  task automatic reset_and_init();
    bit seen;
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (init_done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL init_timeout init_done=%b required=1", init_done);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    w0_valid = 1; w1_valid = 1; rd_valid = 1;
    #1;
    checks++;
    if ({rf_wen, rf_waddr, rf_wdata, rd_resp_valid, rd_resp_data, init_done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs wen=%b waddr=%0d wdata=%h rv=%b rdata=%h done=%b required all 0",
               rf_wen, rf_waddr, rf_wdata, rd_resp_valid, rd_resp_data, init_done);
    end
    checks++;
    if ({w0_ready, w1_ready, rd_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ready got=%b%b%b required=000", w0_ready, w1_ready, rd_ready);
    end
    idle_inputs();
    tick();
    rst_n = 1;
  endtask

  task automatic test_init_sweep();
    w0_valid = 1; w1_valid = 1; rd_valid = 1; w0_addr = 1; w0_data = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== AW'(i) || rf_wdata !== 8'h00) begin
        failures++;
        $display("FAIL sweep_write%0d wen=%b addr=%0d data=%h required 1/%0d/00", i, rf_wen, rf_waddr, rf_wdata, i);
      end
      checks++;
      if ({w0_ready, w1_ready, rd_ready, init_done, rd_resp_valid} !== 5'b0) begin
        failures++;
        $display("FAIL sweep_blocked%0d ready=%b%b%b done=%b rv=%b required 0", i, w0_ready, w1_ready, rd_ready, init_done, rd_resp_valid);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (init_done !== 1'b1 || rf_wen !== 1'b0 || rd_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL sweep_done done=%b wen=%b rv=%b required 1/0/0", init_done, rf_wen, rd_resp_valid);
    end
  endtask

  task automatic test_alternate();
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    w0_valid = 1; w0_addr = 1; w0_data = 8'h0A;
    w1_valid = 1; w1_addr = 2; w1_data = 8'h0B;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (w0_ready !== (k % 2 == 0) || w1_ready !== (k % 2 == 1)) begin
        failures++;
        $display("FAIL alt_grant%0d ready=%b%b required w%0d", k, w0_ready, w1_ready, k % 2);
      end
      if (k > 0) begin
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== prev_addr || rf_wdata !== prev_data) begin
          failures++;
          $display("FAIL alt_write%0d wen=%b addr=%0d data=%h required 1/%0d/%h", k, rf_wen, rf_waddr, rf_wdata, prev_addr, prev_data);
        end
      end
      prev_addr = (k % 2 == 0) ? AW'(1) : AW'(2);
      prev_data = (k % 2 == 0) ? 8'h0A : 8'h0B;
      tick();
    end
    idle_inputs();
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== prev_addr) begin
      failures++;
      $display("FAIL alt_last wen=%b addr=%0d required 1/%0d", rf_wen, rf_waddr, prev_addr);
    end
    tick();
    checks++;
    if (rf_wen !== 1'b0) begin
      failures++;
      $display("FAIL idle_wen wen=%b required 0", rf_wen);
    end
  endtask

  task automatic test_single_w1();
    w1_valid = 1; w1_addr = 0; w1_data = 8'h33;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (w1_ready !== 1'b1 || w0_ready !== 1'b0) begin
        failures++;
        $display("FAIL w1_only%0d ready=%b%b required 01", k, w0_ready, w1_ready);
      end
      tick();
    end
    w0_valid = 1; w0_addr = 0; w0_data = 8'h44;
    #1;
    checks++;
    if (w0_ready !== 1'b1 || w1_ready !== 1'b0) begin
      failures++;
      $display("FAIL w0_after_w1 ready=%b%b required 10", w0_ready, w1_ready);
    end
    tick();
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_read_before_write();
    w0_valid = 1; w0_addr = 3; w0_data = 8'h5C;
    tick();
    w0_valid = 0; rd_valid = 1; rd_addr = 3;
    #1;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== AW'(3) || rd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rbw_setup wen=%b addr=%0d rd_ready=%b required 1/3/1", rf_wen, rf_waddr, rd_ready);
    end
    tick();
    checks++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== 8'h00) begin
      failures++;
      $display("FAIL rbw_old rv=%b data=%h required 1/00", rd_resp_valid, rd_resp_data);
    end
    tick();
    rd_valid = 0;
    checks++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== 8'h5C) begin
      failures++;
      $display("FAIL rbw_new rv=%b data=%h required 1/5c", rd_resp_valid, rd_resp_data);
    end
    tick();
    checks++;
    if (rd_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rbw_single rv=%b required 0", rd_resp_valid);
    end
  endtask

  task automatic test_reset_mid_sweep();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick(); tick(); tick();
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== AW'(2)) begin
      failures++;
      $display("FAIL mid_sweep_pos wen=%b addr=%0d required 1/2", rf_wen, rf_waddr);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (rf_wen !== 1'b0 || rf_waddr !== AW'(0) || init_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_sweep_async wen=%b addr=%0d done=%b required 0/0/0", rf_wen, rf_waddr, init_done);
    end
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== AW'(i)) begin
        failures++;
        $display("FAIL restart_sweep%0d wen=%b addr=%0d required 1/%0d", i, rf_wen, rf_waddr, i);
      end
    end
    tick();
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL restart_done done=%b required 1", init_done);
    end
  endtask

  task automatic test_back_to_back_reads();
    for (int i = 0; i < 4; i++) begin
      w0_valid = 1; w0_addr = AW'(i); w0_data = DW'(8'h11 * (i + 1));
      tick();
    end
    idle_inputs();
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        checks++;
        if (rd_resp_valid !== 1'b1 || rd_resp_data !== DW'(8'h11 * i)) begin
          failures++;
          $display("FAIL b2b_read%0d rv=%b data=%h required 1/%h", i - 1, rd_resp_valid, rd_resp_data, DW'(8'h11 * i));
        end
      end
      if (i < 4) begin
        rd_valid = 1; rd_addr = AW'(i);
      end else begin
        rd_valid = 0;
      end
      tick();
    end
    checks++;
    if (rd_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end rv=%b required 0", rd_resp_valid);
    end
  endtask

  // Transaction-level model: RF contents, round-robin winner, one-cycle latencies.
  task automatic test_random();
    logic [DW-1:0] ref_mem [4];
    int            last;
    int            winner;
    bit            exp_wen, exp_rv;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata, exp_rd;
    reset_and_init();
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    last = 1; exp_wen = 0; exp_rv = 0; exp_waddr = '0; exp_wdata = '0; exp_rd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++;
      if (rf_wen !== exp_wen || (exp_wen && (rf_waddr !== exp_waddr || rf_wdata !== exp_wdata))) begin
        failures++;
        $display("FAIL rnd_write c%0d wen=%b addr=%0d data=%h required %b/%0d/%h", cyc, rf_wen, rf_waddr, rf_wdata, exp_wen, exp_waddr, exp_wdata);
      end
      checks++;
      if (rd_resp_valid !== exp_rv || (exp_rv && rd_resp_data !== exp_rd)) begin
        failures++;
        $display("FAIL rnd_read c%0d rv=%b data=%h required %b/%h", cyc, rd_resp_valid, rd_resp_data, exp_rv, exp_rd);
      end
      w0_valid = 1'($urandom_range(0, 1)); w0_addr = AW'($urandom); w0_data = DW'($urandom);
      w1_valid = 1'($urandom_range(0, 1)); w1_addr = AW'($urandom); w1_data = DW'($urandom);
      rd_valid = 1'($urandom_range(0, 1)); rd_addr = AW'($urandom);
      #1;
      if (w0_valid && w1_valid) winner = 1 - last;
      else if (w0_valid)        winner = 0;
      else if (w1_valid)        winner = 1;
      else                      winner = -1;
      checks++;
      if (w0_ready !== (winner == 0) || w1_ready !== (winner == 1) || rd_ready !== 1'b1) begin
        failures++;
        $display("FAIL rnd_grant c%0d ready=%b%b rd=%b required winner %0d", cyc, w0_ready, w1_ready, rd_ready, winner);
      end
      exp_rv = rd_valid;
      exp_rd = ref_mem[rd_addr];
      if (exp_wen) ref_mem[exp_waddr] = exp_wdata;
      exp_wen = (winner >= 0);
      if (winner == 0) begin exp_waddr = w0_addr; exp_wdata = w0_data; last = 0; end
      if (winner == 1) begin exp_waddr = w1_addr; exp_wdata = w1_data; last = 1; end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1;
    idle_inputs();
    #2;
    test_reset();
    test_init_sweep();
    test_alternate();
    test_single_w1();
    test_read_before_write();
    test_reset_mid_sweep();
    test_back_to_back_reads();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
